// File: rtl/channel_delay_gen.sv
// Four-channel programmable delay/pulse generator: a start edge arms every enabled channel,
// which waits its delay, emits one gate pulse of programmed width, then holds DONE until cleared.
module channel_delay_gen #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DLY_W = 32,
   parameter int unsigned WID_W = 16
) (
   input  logic                    i_clk,
   input  logic                    w_main_reset,
   input  logic                    i_start,
   input  logic [N_CH-1:0]         i_channel_enable,
   input  logic [N_CH*DLY_W-1:0]   i_delay,
   input  logic [N_CH*WID_W-1:0]   i_width,
   input  logic [N_CH-1:0]         i_reset_ch,
   output logic [N_CH-1:0]         o_channel_gen_signal,
   output logic [N_CH-1:0]         o_channel_latch,
   output logic                    o_start_latch,
   output logic                    o_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [N_CH-1:0][1:0]       r_state;
   logic [N_CH-1:0][1:0]       state_nxt;
   logic [N_CH-1:0][DLY_W-1:0] r_dcnt;
   logic [N_CH-1:0][DLY_W-1:0] dcnt_nxt;
   logic [N_CH-1:0][WID_W-1:0] r_wcnt;
   logic [N_CH-1:0][WID_W-1:0] wcnt_nxt;
   logic [N_CH-1:0][WID_W-1:0] r_wid;
   logic [N_CH-1:0][WID_W-1:0] wid_nxt;
   logic                       r_start_d;
   logic                       all_idle_c;
   logic                       start_ok_c;
   logic [N_CH-1:0]            gen_nxt;
   logic [N_CH-1:0]            latch_nxt;
   logic                       busy_nxt;
   logic                       start_latch_nxt;

   // A start edge is only honoured when every channel is back in IDLE
   always_comb begin
      all_idle_c = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         if (r_state[k] != S_IDLE) all_idle_c = 1'b0;
      end
   end

   assign start_ok_c = i_start & ~r_start_d & all_idle_c;

   // State register; outputs are registered here from their next values
   always_ff @(posedge i_clk or posedge w_main_reset) begin
      if (w_main_reset) begin
         r_state              <= '0;
         r_dcnt               <= '0;
         r_wcnt               <= '0;
         r_wid                <= '0;
         r_start_d            <= 1'b1;
         o_channel_gen_signal <= '0;
         o_channel_latch      <= '0;
         o_start_latch        <= 1'b0;
         o_busy               <= 1'b0;
      end else begin
         r_state              <= state_nxt;
         r_dcnt               <= dcnt_nxt;
         r_wcnt               <= wcnt_nxt;
         r_wid                <= wid_nxt;
         r_start_d            <= i_start;
         o_channel_gen_signal <= gen_nxt;
         o_channel_latch      <= latch_nxt;
         o_start_latch        <= start_latch_nxt;
         o_busy               <= busy_nxt;
      end
   end

   // Per-channel next state; a channel clear overrides everything, including an accepted start
   always_comb begin
      state_nxt = r_state;
      dcnt_nxt  = r_dcnt;
      wcnt_nxt  = r_wcnt;
      wid_nxt   = r_wid;
      for (int k = 0; k < N_CH; k++) begin
         case (r_state[k])
            S_IDLE: begin
               if (start_ok_c && i_channel_enable[k]) begin
                  state_nxt[k] = S_DELAY;
                  dcnt_nxt[k]  = i_delay[k*DLY_W +: DLY_W];
                  wid_nxt[k]   = i_width[k*WID_W +: WID_W];
               end
            end
            S_DELAY: begin
               if (r_dcnt[k] == '0) begin
                  state_nxt[k] = S_PULSE;
                  wcnt_nxt[k]  = (r_wid[k] == '0) ? '0 : r_wid[k] - WID_W'(1);
               end else begin
                  dcnt_nxt[k] = r_dcnt[k] - DLY_W'(1);
               end
            end
            S_PULSE: begin
               if (r_wcnt[k] == '0) state_nxt[k] = S_DONE;
               else                 wcnt_nxt[k]  = r_wcnt[k] - WID_W'(1);
            end
            default: state_nxt[k] = S_DONE;
         endcase
         if (i_reset_ch[k]) begin
            state_nxt[k] = S_IDLE;
            dcnt_nxt[k]  = '0;
            wcnt_nxt[k]  = '0;
         end
      end
   end

   // Output decode from the next state so the registered outputs track the state exactly
   always_comb begin
      gen_nxt   = '0;
      latch_nxt = '0;
      busy_nxt  = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         gen_nxt[k]   = (state_nxt[k] == S_PULSE);
         latch_nxt[k] = (state_nxt[k] != S_IDLE);
         if (state_nxt[k] == S_DELAY || state_nxt[k] == S_PULSE) busy_nxt = 1'b1;
      end
      start_latch_nxt = o_start_latch;
      if (start_ok_c)      start_latch_nxt = 1'b1;
      else if (all_idle_c) start_latch_nxt = 1'b0;
   end

endmodule

// File: tb/tb_channel_delay_gen.sv
// Bench for channel_delay_gen: a monitor logs every gate pulse (channel, rise cycle, width);
// each scenario pushes the pulses it expects and compares them against the log.
module tb_channel_delay_gen;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned DLY_W = 32;
   localparam int unsigned WID_W = 16;

   typedef struct packed {
      int ch;
      int rise;
      int width;
   } pulse_t;

   logic                  i_clk = 1'b0;
   logic                  w_main_reset = 1'b0;
   logic                  i_start = 1'b0;
   logic [N_CH-1:0]       i_channel_enable = '0;
   logic [N_CH*DLY_W-1:0] i_delay = '0;
   logic [N_CH*WID_W-1:0] i_width = '0;
   logic [N_CH-1:0]       i_reset_ch = '0;
   logic [N_CH-1:0]       o_channel_gen_signal;
   logic [N_CH-1:0]       o_channel_latch;
   logic                  o_start_latch;
   logic                  o_busy;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   pulse_t exp_q[$];
   pulse_t obs_q[$];
   pulse_t e, o;
   logic [N_CH-1:0] prev = '0;
   int     rise_at[N_CH];
   int     len[N_CH];
   logic [N_CH*DLY_W-1:0] force_val;

   channel_delay_gen #(.N_CH(N_CH), .DLY_W(DLY_W), .WID_W(WID_W)) dut (
      .i_clk(i_clk), .w_main_reset(w_main_reset), .i_start(i_start),
      .i_channel_enable(i_channel_enable), .i_delay(i_delay), .i_width(i_width),
      .i_reset_ch(i_reset_ch), .o_channel_gen_signal(o_channel_gen_signal),
      .o_channel_latch(o_channel_latch), .o_start_latch(o_start_latch), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Pulse monitor: rise is the count of active edges at the first high sample
   always @(negedge i_clk) begin
      for (int k = 0; k < N_CH; k++) begin
         if (o_channel_gen_signal[k]) begin
            if (!prev[k]) begin
               rise_at[k] = cyc;
               len[k] = 1;
            end else begin
               len[k] = len[k] + 1;
            end
         end else if (prev[k]) begin
            obs_q.push_back('{ch: k, rise: rise_at[k], width: len[k]});
         end
      end
      prev = o_channel_gen_signal;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // Raise i_start for one cycle; t0 is the edge that samples it
   task automatic pulse_start(output int t0);
      i_start = 1'b1;
      t0 = cyc + 1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic set_ch(input int k, input logic [DLY_W-1:0] d, input logic [WID_W-1:0] w);
      i_delay[k*DLY_W +: DLY_W] = d;
      i_width[k*WID_W +: WID_W] = w;
   endtask

   task automatic test_reset;
      #2 w_main_reset = 1'b1;
      #1;
      checks++;
      if ({o_channel_gen_signal, o_channel_latch, o_start_latch, o_busy} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0",
                  {o_channel_gen_signal, o_channel_latch, o_start_latch, o_busy});
      end
      tick(3);
      w_main_reset = 1'b0;
      tick(2);
      checks++;
      if (o_busy !== 1'b0 || o_start_latch !== 1'b0) begin
         errors++;
         $display("FAIL reset_release busy %b start_latch %b expected 0 0", o_busy, o_start_latch);
      end
   endtask

   task automatic test_all_channels;
      int t0;
      i_channel_enable = 4'b1111;
      set_ch(0, 0, 1); set_ch(1, 1, 2); set_ch(2, 5, 3); set_ch(3, 100, 0);
      pulse_start(t0);
      checks++;
      if (o_channel_latch !== 4'b1111 || o_start_latch !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL all_arm latch %b start %b busy %b expected 1111 1 1",
                  o_channel_latch, o_start_latch, o_busy);
      end
      exp_q.push_back('{ch: 0, rise: t0 + 1,   width: 1});
      exp_q.push_back('{ch: 1, rise: t0 + 2,   width: 2});
      exp_q.push_back('{ch: 2, rise: t0 + 6,   width: 3});
      exp_q.push_back('{ch: 3, rise: t0 + 101, width: 1});
      tick(105);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL all_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL all_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL all_extra got %0d extra pulses expected 0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (o_channel_latch !== 4'b1111 || o_busy !== 1'b0 || o_start_latch !== 1'b1) begin
         errors++;
         $display("FAIL all_done latch %b busy %b start %b expected 1111 0 1",
                  o_channel_latch, o_busy, o_start_latch);
      end
      i_reset_ch = 4'b1111;
      tick(1);
      i_reset_ch = 4'b0000;
      checks++;
      if (o_channel_latch !== 4'b0000 || o_start_latch !== 1'b1) begin
         errors++;
         $display("FAIL all_clear latch %b start %b expected 0000 1", o_channel_latch, o_start_latch);
      end
      tick(1);
      checks++;
      if (o_start_latch !== 1'b0) begin
         errors++;
         $display("FAIL all_start_drop got %b expected 0", o_start_latch);
      end
   endtask

   task automatic test_partial_enable;
      int t0;
      i_channel_enable = 4'b0101;
      for (int k = 0; k < N_CH; k++) set_ch(k, 10, 4);
      pulse_start(t0);
      checks++;
      if (o_channel_latch !== 4'b0101) begin
         errors++;
         $display("FAIL part_latch got %b expected 0101", o_channel_latch);
      end
      exp_q.push_back('{ch: 0, rise: t0 + 11, width: 4});
      exp_q.push_back('{ch: 2, rise: t0 + 11, width: 4});
      tick(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL part_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL part_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL part_extra got %0d extra pulses expected 0", obs_q.size());
         obs_q.delete();
      end
      i_reset_ch = 4'b0101;
      tick(1);
      i_reset_ch = 4'b0000;
      checks++;
      if (o_channel_latch !== 4'b0000 || o_start_latch !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL part_clear latch %b start %b busy %b expected 0000 1 0",
                  o_channel_latch, o_start_latch, o_busy);
      end
      tick(1);
      checks++;
      if (o_start_latch !== 1'b0) begin
         errors++;
         $display("FAIL part_start_drop got %b expected 0", o_start_latch);
      end
   endtask

   task automatic test_back_to_back;
      int t0, t_ign, t1;
      i_channel_enable = 4'b0001;
      set_ch(0, 20, 2);
      pulse_start(t0);
      tick(4);
      pulse_start(t_ign);
      exp_q.push_back('{ch: 0, rise: t0 + 21, width: 2});
      tick(25);
      i_reset_ch = 4'b0001;
      tick(1);
      i_reset_ch = 4'b0000;
      tick(1);
      set_ch(0, 0, 1);
      pulse_start(t1);
      exp_q.push_back('{ch: 0, rise: t1 + 1, width: 1});
      tick(4);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL b2b_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra got %0d extra pulses expected 0", obs_q.size());
         obs_q.delete();
      end
      i_reset_ch = 4'b0001;
      tick(1);
      i_reset_ch = 4'b0000;
      tick(1);
   endtask

   task automatic test_main_reset;
      int t0, t1;
      i_channel_enable = 4'b0010;
      set_ch(1, 3, 20);
      pulse_start(t0);
      tick(9);
      @(posedge i_clk);
      #1 w_main_reset = 1'b1;
      i_start = 1'b1;
      #1;
      checks++;
      if ({o_channel_gen_signal, o_channel_latch, o_busy, o_start_latch} !== 10'b0) begin
         errors++;
         $display("FAIL mreset_async got %b expected 0",
                  {o_channel_gen_signal, o_channel_latch, o_busy, o_start_latch});
      end
      exp_q.push_back('{ch: 1, rise: t0 + 4, width: 6});
      tick(2);
      w_main_reset = 1'b0;
      tick(6);
      checks++;
      if (o_channel_latch !== 4'b0000 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL mreset_held_start latch %b busy %b expected 0000 0", o_channel_latch, o_busy);
      end
      i_start = 1'b0;
      tick(1);
      pulse_start(t1);
      exp_q.push_back('{ch: 1, rise: t1 + 4, width: 20});
      tick(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL mreset_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL mreset_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL mreset_extra got %0d extra pulses expected 0", obs_q.size());
         obs_q.delete();
      end
      i_reset_ch = 4'b0010;
      tick(1);
      i_reset_ch = 4'b0000;
      tick(1);
   endtask

   task automatic test_channel_clear;
      int t0;
      i_channel_enable = 4'b1111;
      for (int k = 0; k < N_CH; k++) set_ch(k, 10, 1);
      i_reset_ch = 4'b0010;
      pulse_start(t0);
      i_reset_ch = 4'b0000;
      checks++;
      if (o_channel_latch !== 4'b1101) begin
         errors++;
         $display("FAIL clr_on_start latch got %b expected 1101", o_channel_latch);
      end
      tick(2);
      i_reset_ch = 4'b0100;
      tick(1);
      i_reset_ch = 4'b0000;
      checks++;
      if (o_channel_latch !== 4'b1001 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL clr_mid_delay latch %b busy %b expected 1001 1", o_channel_latch, o_busy);
      end
      exp_q.push_back('{ch: 0, rise: t0 + 11, width: 1});
      exp_q.push_back('{ch: 3, rise: t0 + 11, width: 1});
      tick(12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL clr_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL clr_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL clr_extra got %0d extra pulses expected 0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (o_channel_latch !== 4'b1001) begin
         errors++;
         $display("FAIL clr_final latch got %b expected 1001", o_channel_latch);
      end
      i_reset_ch = 4'b1001;
      tick(1);
      i_reset_ch = 4'b0000;
      tick(1);
   endtask

   task automatic test_long_delay;
      int t0, c;
      i_channel_enable = 4'b0001;
      set_ch(0, 32'hFFFF_FFFF, 1);
      pulse_start(t0);
      tick(3);
      checks++;
      if (o_busy !== 1'b1 || o_channel_gen_signal !== 4'b0000) begin
         errors++;
         $display("FAIL long_wait busy %b gen %b expected 1 0000", o_busy, o_channel_gen_signal);
      end
      force_val = '0;
      force_val[DLY_W-1:0] = 32'd1;
      c = cyc;
      force dut.r_dcnt = force_val;
      #1 release dut.r_dcnt;
      exp_q.push_back('{ch: 0, rise: c + 2, width: 1});
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL long_pulse missing ch%0d rise %0d width %0d", e.ch, e.rise, e.width);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL long_pulse got ch%0d rise %0d width %0d expected ch%0d rise %0d width %0d",
                        o.ch, o.rise, o.width, e.ch, e.rise, e.width);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0 || o_channel_latch !== 4'b0001 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL long_done extra %0d latch %b busy %b expected 0 0001 0",
                  obs_q.size(), o_channel_latch, o_busy);
         obs_q.delete();
      end
      i_reset_ch = 4'b0001;
      tick(1);
      i_reset_ch = 4'b0000;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_all_channels();
      test_partial_enable();
      test_back_to_back();
      test_main_reset();
      test_channel_clear();
      test_long_delay();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
